// File: rtl/uart_echo_top.sv
// uart_echo_top -- IceStick UART echo demo.
//
// Receives 8N1 bytes on RS232_Rx_TTL, shows the low nibble of the last good
// byte on LED0..LED3, toggles LED4 per good byte and (when UART_ECHO_EN is
// defined) echoes every good byte back on RS232_Tx_TTL. With UART_ECHO_EN
// undefined the TX path and pending buffer are not built and the TX line is
// held high.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (12 MHz / 9600 = 1250), >= 4
// Ports:
//   iCE_CLK       system clock, rising edge
//   rst_n         asynchronous active-low reset
//   RS232_Rx_TTL  serial input, idles high, asynchronous to iCE_CLK
//   RS232_Tx_TTL  serial output, idles high
//   LED0..LED3    bits 3:0 of the last valid received byte
//   LED4          toggles on every valid received byte
module uart_echo_top #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic iCE_CLK,
  input  logic rst_n,
  input  logic RS232_Rx_TTL,
  output logic RS232_Tx_TTL,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // ---- RX synchronizer ----
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RS232_Rx_TTL;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---- RX deserializer ----
  rx_state_t       rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_idx_q;
  logic            rx_valid_q;
  logic [7:0]      rx_shift_q;
  logic            rx_sample_d;

  assign rx_sample_d = (rx_state_q == RX_DATA) && (rx_cnt_q == BIT_LAST);

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxs_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
            // A line that is high again at mid start bit was only a glitch.
            rx_state_q <= rxs_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            // Leave at mid stop bit so an immediately following start bit
            // is still caught by IDLE.
            if (rxs_q) begin
              rx_valid_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in at the MSB end.
  always_ff @(posedge iCE_CLK) begin
    if (rx_sample_d) begin
      rx_shift_q <= {rxs_q, rx_shift_q[7:1]};
    end
  end

  // ---- LED registers ----
  logic [3:0] led_q;
  logic       led4_q;

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      led4_q <= 1'b0;
    end else if (rx_valid_q) begin
      led_q  <= rx_shift_q[3:0];
      led4_q <= ~led4_q;
    end
  end

  assign LED0 = led_q[0];
  assign LED1 = led_q[1];
  assign LED2 = led_q[2];
  assign LED3 = led_q[3];
  assign LED4 = led4_q;

`ifdef UART_ECHO_EN
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // ---- TX serializer and pending buffer ----
  tx_state_t       tx_state_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_idx_q;
  logic            tx_q;
  logic [7:0]      tx_shift_q;
  logic [7:0]      buf_q;
  logic            buf_full_q;

  logic            tx_free_d;
  logic            tx_load_rx_d;
  logic            tx_load_buf_d;
  logic            tx_load_d;
  logic            buf_write_d;
  logic [7:0]      tx_byte_d;

  // TX can accept a new byte when idle or in the last cycle of its stop bit,
  // so back-to-back echoes run without an extra idle cycle.
  assign tx_free_d     = (tx_state_q == TX_IDLE) ||
                         ((tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST));
  // The buffer always holds an older byte than rx, so it goes out first.
  assign tx_load_buf_d = tx_free_d && buf_full_q;
  assign tx_load_rx_d  = rx_valid_q && tx_free_d && !buf_full_q;
  assign tx_load_d     = tx_load_buf_d || tx_load_rx_d;
  assign buf_write_d   = rx_valid_q && !tx_load_rx_d;
  assign tx_byte_d     = tx_load_buf_d ? buf_q : rx_shift_q;

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
    end else if (buf_write_d) begin
      // Overwrites a full buffer: newest byte wins.
      buf_full_q <= 1'b1;
    end else if (tx_load_buf_d) begin
      buf_full_q <= 1'b0;
    end
  end

  always_ff @(posedge iCE_CLK) begin
    if (buf_write_d) begin
      buf_q <= rx_shift_q;
    end
    if (tx_load_d) begin
      tx_shift_q <= tx_byte_d;
    end else if ((tx_state_q == TX_DATA) && (tx_cnt_q == BIT_LAST)) begin
      tx_shift_q <= {1'b0, tx_shift_q[7:1]};
    end
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_load_d) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_q       <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_idx_q <= tx_idx_q + 1'b1;
              // Shift register moves on this same edge; bit 1 is next.
              tx_q     <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_load_d) begin
              tx_state_q <= TX_START;
              tx_q       <= 1'b0;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign RS232_Tx_TTL = tx_q;
`else
  assign RS232_Tx_TTL = 1'b1;
`endif

endmodule

// File: tb/tb_uart_echo_top.sv
module tb_uart_echo_top;

  localparam int CPB = 16;
`ifdef UART_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  logic led0, led1, led2, led3, led4;

  always #5 clk = ~clk;

  uart_echo_top #(.CLKS_PER_BIT(CPB)) dut (
    .iCE_CLK      (clk),
    .rst_n        (rst_n),
    .RS232_Rx_TTL (rx),
    .RS232_Tx_TTL (tx),
    .LED0         (led0),
    .LED1         (led1),
    .LED2         (led2),
    .LED3         (led3),
    .LED4         (led4)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: every good frame sent is expected once on TX, in order.
  logic [7:0] exp_q[$];
  logic [3:0] exp_led = 4'h0;
  logic       exp_led4 = 1'b0;

  // TX line decoder.
  logic [7:0] mon_q[$];
  time        mon_t_q[$];
  int         mon_bad = 0;
  int         tx_low_cnt = 0;
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  int         mon_k = 0;
  logic [7:0] mon_byte = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (tx === 1'b0) tx_low_cnt++;
        if (!mon_active) begin
          if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt = 0;
            mon_t_q.push_back($time);
          end
        end else begin
          mon_cnt++;
          if (mon_cnt == CPB / 2) begin
            if (tx !== 1'b0) begin
              mon_bad++;
              mon_active = 1'b0;
            end
          end else if (mon_cnt > CPB / 2 && ((mon_cnt - CPB / 2) % CPB) == 0) begin
            mon_k = (mon_cnt - CPB / 2) / CPB;
            if (mon_k <= 8) begin
              mon_byte[mon_k-1] = tx;
            end else begin
              if (tx !== 1'b1) mon_bad++;
              else mon_q.push_back(mon_byte);
              mon_active = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Starts and ends on a falling clock edge; one frame is exactly 10 bit-times.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (stop) begin
      exp_led  = b[3:0];
      exp_led4 = ~exp_led4;
      if (ECHO) exp_q.push_back(b);
    end
  endtask

  // Waits for all expected echoes (bounded), then a quiet period to catch extras.
  task automatic wait_drain();
    for (int c = 0; c < 40 * CPB; c++) begin
      if (mon_q.size() >= exp_q.size() && !mon_active) break;
      @(negedge clk);
    end
    repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_tx: got %b want 1", tx);
    end
    vectors++;
    if ({led4, led3, led2, led1, led0} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_leds: got %b want 00000", {led4, led3, led2, led1, led0});
    end
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_single_frame();
    time t0;
    longint lat;
    longint base;
    mon_t_q.delete();
    t0 = $time;
    send_frame(8'h55, 1'b1);
    vectors++;
    if ({led3, led2, led1, led0} !== exp_led || led4 !== exp_led4) begin
      miscompares++;
      $display("FAIL single_leds: got %b%b%b%b_%b want %b_%b",
               led3, led2, led1, led0, led4, exp_led, exp_led4);
    end
    wait_drain();
    vectors++;
    if (mon_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_echo_count: got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (mon_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_echo_byte[%0d]: got %h want %h", i, mon_q[i], exp_q[i]);
      end
    end
`ifdef UART_ECHO_EN
    base = 2 + CPB / 2 + 9 * CPB;
    lat = (mon_t_q.size() == 0) ? -1 : longint'((mon_t_q[0] - t0) / 10);
    vectors++;
    if (lat < base || lat > base + 3) begin
      miscompares++;
      $display("FAIL single_echo_latency: got %0d cycles want %0d..%0d", lat, base, base + 3);
    end
`else
    vectors++;
    if (tx_low_cnt != 0) begin
      miscompares++;
      $display("FAIL tx_held_high: got %0d low cycles want 0", tx_low_cnt);
    end
`endif
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      send_frame(8'h55, 1'b1);
      vectors++;
      if ({led3, led2, led1, led0} !== exp_led || led4 !== exp_led4) begin
        miscompares++;
        $display("FAIL b2b_leds[%0d]: got %b%b%b%b_%b want %b_%b", f,
                 led3, led2, led1, led0, led4, exp_led, exp_led4);
      end
    end
    wait_drain();
    vectors++;
    if (mon_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_echo_count: got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (mon_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_echo_byte[%0d]: got %h want %h", i, mon_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic test_glitch();
    int low_before;
    low_before = tx_low_cnt;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    vectors++;
    if ({led3, led2, led1, led0} !== exp_led || led4 !== exp_led4) begin
      miscompares++;
      $display("FAIL glitch_leds: got %b%b%b%b_%b want %b_%b",
               led3, led2, led1, led0, led4, exp_led, exp_led4);
    end
    vectors++;
    if (tx_low_cnt != low_before) begin
      miscompares++;
      $display("FAIL glitch_tx_quiet: got %0d low cycles want %0d", tx_low_cnt, low_before);
    end
  endtask

  task automatic test_framing_error();
    send_frame(8'hA3, 1'b0);
    vectors++;
    if ({led3, led2, led1, led0} !== exp_led || led4 !== exp_led4) begin
      miscompares++;
      $display("FAIL framing_bad_leds: got %b%b%b%b_%b want %b_%b",
               led3, led2, led1, led0, led4, exp_led, exp_led4);
    end
    repeat (CPB) @(negedge clk);
    send_frame(8'h0F, 1'b1);
    vectors++;
    if ({led3, led2, led1, led0} !== 4'hF || led4 !== exp_led4) begin
      miscompares++;
      $display("FAIL framing_good_leds: got %b%b%b%b_%b want 1111_%b",
               led3, led2, led1, led0, led4, exp_led4);
    end
    wait_drain();
    vectors++;
    if (mon_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL framing_echo_count: got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (mon_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL framing_echo_byte[%0d]: got %h want %h", i, mon_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h96;
    send_frame(8'hA5, 1'b1);
    // Next frame: start bit and data bits 0..3, reset halfway through bit 4
    // while the echo of 0xA5 is still on the line.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_tx_async: got %b want 1", tx);
    end
    exp_led  = 4'h0;
    exp_led4 = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    vectors++;
    if ({led4, led3, led2, led1, led0} !== 5'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_hold: got leds %b tx %b want leds 00000 tx 1",
               {led4, led3, led2, led1, led0}, tx);
    end
    rx = 1'b1;
    rst_n = 1'b1;
    mon_q.delete();
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    vectors++;
    if ({led3, led2, led1, led0} !== 4'b1100 || led4 !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_leds: got %b%b%b%b_%b want 1100_1",
               led3, led2, led1, led0, led4);
    end
    wait_drain();
    vectors++;
    if (mon_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midreset_echo_count: got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (mon_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midreset_echo_byte[%0d]: got %h want %h", i, mon_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int         gap;
    for (int f = 0; f < 24; f++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(b, stop);
      vectors++;
      if ({led3, led2, led1, led0} !== exp_led || led4 !== exp_led4) begin
        miscompares++;
        $display("FAIL random_leds[%0d]: got %b%b%b%b_%b want %b_%b", f,
                 led3, led2, led1, led0, led4, exp_led, exp_led4);
      end
      repeat (gap * CPB) @(negedge clk);
    end
    wait_drain();
    vectors++;
    if (mon_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_echo_count: got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (mon_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_echo_byte[%0d]: got %h want %h", i, mon_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (mon_bad != 0) begin
      miscompares++;
      $display("FAIL tx_frame_format: got %0d malformed frames want 0", mon_bad);
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_echo_top.md
# uart_echo_top

Board-level UART demo for the iCE40 IceStick. It receives 8N1 serial bytes on the RS-232 TTL input at 9600 baud from a 12 MHz clock and echoes each valid byte back on the TX line. It also shows the low nibble of the last received byte on LED0–LED3 and toggles LED4 once per received byte. It is the top-level wrapper: an RX deserializer, a one-byte pending buffer, a TX serializer and the LED registers.

## Interface
Parameters:
- CLKS_PER_BIT, 1250, clock cycles per UART bit (12 000 000 / 9600); must be ≥ 4.

Ports:
- iCE_CLK  in  1  system clock (12 MHz on the board); all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- RS232_Rx_TTL  in  1  serial input; idles high; asynchronous to iCE_CLK.
- RS232_Tx_TTL  out  1  serial output; idles high.
- LED0  out  1  last valid byte bit 0.
- LED1  out  1  last valid byte bit 1.
- LED2  out  1  last valid byte bit 2.
- LED3  out  1  last valid byte bit 3.
- LED4  out  1  toggles on each valid received byte.

## Operation
Reset (rst_n low):
- RS232_Tx_TTL = 1, LED0–LED4 = 0.
- Synchronizer flops = 1, pending buffer empty, RX and TX FSMs in IDLE.

RX input:
- RS232_Rx_TTL passes through a 2-flop synchronizer; the RX FSM uses only the synchronized signal (rxs).

RX FSM:
- IDLE: when rxs = 0, go to START with counter = 0.
- START: at count CLKS_PER_BIT/2 − 1 (mid start bit), sample rxs. If it is 1, treat it as a glitch and return to IDLE. If it is 0, go to DATA with bit index 0 and counter reset.
- DATA: every CLKS_PER_BIT cycles, sample rxs into bit[index], LSB first. After bit 7, go to STOP.
- STOP: CLKS_PER_BIT cycles after the bit-7 sample, sample rxs.
  - 1 → byte valid: assert internal rx_valid for 1 cycle and return to IDLE immediately, at mid stop bit, so a back-to-back start bit is caught.
  - 0 → framing error: discard the byte and go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs = 1, then go to IDLE.

On rx_valid:
- LED0..LED3 ← byte[3:0] and LED4 ← ~LED4 on the same clock edge.
- If TX is IDLE and the pending buffer is empty, the byte goes directly to TX. Otherwise it is written into the pending buffer; a full buffer is overwritten (newest byte wins).

TX FSM:
- States IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE; each bit lasts exactly CLKS_PER_BIT cycles.
- In IDLE with the pending buffer full, the buffer is loaded and cleared in the same cycle.
- If rx_valid coincides with TX returning to IDLE while the buffer is empty, the new byte starts transmitting directly.

## Timing
- RX latency: rx_valid occurs 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (±1) after the RX falling edge; this is 11 877 cycles at the default.
- LEDs update on the edge that sees rx_valid.
- Echo latency: RS232_Tx_TTL goes low (start bit) on the clock edge after rx_valid when TX is idle.
- TX frame length: 10·CLKS_PER_BIT cycles, stop bit included.
- Back-to-back input frames (each 10 bit-times) echo without loss; the pending buffer absorbs the ±1-cycle phase overlap.
- Reset asserted mid-frame aborts RX and TX immediately; RS232_Tx_TTL returns high asynchronously.

## Configuration
- UART_ECHO_EN
  - Defined: RX bytes are echoed on RS232_Tx_TTL as described above.
  - Undefined: the TX path and pending buffer are not built, RS232_Tx_TTL is tied to 1, and RX/LED behaviour is unchanged.

## Test plan
- Single frame 0x55 (start, data bits 1,0,1,0,1,0,1,0, stop; 1250 cycles per bit):
  - LED0..3 = 1,0,1,0 and LED4 = 1.
  - TX emits 0x55 starting about 11 878 cycles after the start edge.
- Four back-to-back 0x55 frames with no idle gap:
  - Four 0x55 echoes on TX with correct bit timing.
  - LED4 ends at 0.
- Glitch: RX low for 300 cycles, then high:
  - No rx_valid, LEDs unchanged, TX stays high.
- Framing error: frame 0xA3 with stop bit 0, then line high, then a valid 0x0F:
  - 0xA3 is discarded.
  - LED0..3 = 1,1,1,1, LED4 toggles once, TX echoes only 0x0F.
- Reset mid-frame: assert rst_n low during data bit 4, release, then send 0x3C:
  - During reset, all LEDs are 0 and TX is 1.
  - After release, LED0..3 = 0,0,1,1 and 0x3C is echoed.
- UART_ECHO_EN undefined: send 0x55:
  - LEDs update as in the single-frame test.
  - RS232_Tx_TTL stays constant 1.
